// File: rtl/gnrc_id_alloc.sv
// ID allocator: offers the lowest free ID from a pool of 2**N over valid/ready
// and takes IDs back on a free port, flagging frees of IDs that are not held.

module gnrc_bin2onehot #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]    bin_i,
  output logic [2**N-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[bin_i] = 1'b1;
  end

endmodule

module gnrc_id_alloc #(
  parameter int unsigned N = 3,
  parameter int unsigned M = 2**N
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic         alloc_valid_o,
  input  logic         alloc_ready_i,
  output logic [N-1:0] alloc_id_o,
  input  logic         free_valid_i,
  input  logic [N-1:0] free_id_i,
  output logic [M-1:0] used_o,
  output logic [N:0]   count_o,
  output logic         full_o,
  output logic         err_o
);

  localparam logic [N:0] M_CNT = M[N:0];

  logic [M-1:0] used_q, used_d;
  logic         offer_vld_q, offer_vld_d;
  logic [N-1:0] offer_id_q, offer_id_d;
  logic [N:0]   cnt_q, cnt_d;
  logic         err_q, err_d;

  logic [M-1:0] free_oh;
  logic [M-1:0] offer_oh;
  logic [M-1:0] cand;
  logic         handshake;
  logic         free_legal;
  logic         pick_vld;
  logic [N-1:0] pick_id;

  gnrc_bin2onehot #(.N(N)) u_free_dec (
    .bin_i    (free_id_i),
    .onehot_o (free_oh)
  );

  gnrc_bin2onehot #(.N(N)) u_offer_dec (
    .bin_i    (offer_id_q),
    .onehot_o (offer_oh)
  );

  assign handshake  = offer_vld_q && alloc_ready_i;
  assign free_legal = free_valid_i && ((used_q & free_oh) != '0);

  // The offer bit is masked whenever an offer exists: either it stays reserved
  // or it is being granted this cycle. Pre-update used_q keeps freed slots out.
  assign cand = ~used_q & ~(offer_vld_q ? offer_oh : '0);

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_vld = 1'b1;
        pick_id  = i[N-1:0];
      end
    end
  end

  always_comb begin
    used_d      = used_q;
    offer_vld_d = offer_vld_q;
    offer_id_d  = offer_id_q;
    cnt_d       = cnt_q;
    err_d       = free_valid_i && !free_legal;

    if (handshake) begin
      used_d = used_d | offer_oh;
    end
    if (free_legal) begin
      used_d = used_d & ~free_oh;
    end
    cnt_d = cnt_q + {{N{1'b0}}, handshake} - {{N{1'b0}}, free_legal};

    if (!offer_vld_q || handshake) begin
      offer_vld_d = pick_vld;
      if (pick_vld) begin
        offer_id_d = pick_id;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      used_q      <= '0;
      offer_vld_q <= 1'b0;
      offer_id_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      used_q      <= used_d;
      offer_vld_q <= offer_vld_d;
      offer_id_q  <= offer_id_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign alloc_valid_o = offer_vld_q;
  assign alloc_id_o    = offer_id_q;
  assign used_o        = used_q;
  assign count_o       = cnt_q;
  assign full_o        = (cnt_q == M_CNT);
  assign err_o         = err_q;

endmodule
